// File: rtl/maj_pkg.sv
// Shared types and sizing helpers for the folded majority evaluator.
package maj_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  function automatic int f_cw(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int f_passes(input int n, input int chunk);
    return (n + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/maj_chunk_popcount.sv
// Combinational popcount of one CHUNK-bit slice of the voter vector.
module maj_chunk_popcount #(
  parameter int CHUNK = 7
) (
  input  logic [CHUNK-1:0]               bits,
  output logic [$clog2(CHUNK+1)-1:0]     count
);

  localparam int PCW = $clog2(CHUNK + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + PCW'(bits[i]);
    end
  end

endmodule

// File: rtl/folded_majority_unit.sv
// Folded threshold/majority evaluator: popcounts CHUNK bits per cycle into an
// accumulator, then compares the total against the latched threshold.
module folded_majority_unit
  import maj_pkg::*;
#(
  parameter int N     = 49,
  parameter int CHUNK = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_x,
  input  logic                     in_thr_en,
  input  logic [$clog2(N+1)-1:0]   in_thr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_y,
  output logic [$clog2(N+1)-1:0]   out_count,
  output logic                     busy
);

  localparam int CW      = f_cw(N);
  localparam int PASSES  = f_passes(N, CHUNK);
  localparam int PW      = PASSES * CHUNK;
  localparam int PCW     = $clog2(CHUNK + 1);
  localparam int MAJ_THR = (N + 1) / 2;
  localparam int PCNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_t              state, state_nxt;
  logic                accept;
  logic                last_pass;
  logic [PW-1:0]       shreg;
  logic [CW-1:0]       acc;
  logic [CW-1:0]       acc_nxt;
  logic [CW-1:0]       thr;
  logic [PCW-1:0]      chunk_cnt;
  logic [PCNT_W-1:0]   pass_cnt;

  maj_chunk_popcount #(.CHUNK(CHUNK)) u_chunk_popcount (
    .bits  (shreg[CHUNK-1:0]),
    .count (chunk_cnt)
  );

  // CHUNK <= N, so the chunk count always fits in CW bits.
  assign acc_nxt   = acc + CW'(chunk_cnt);
  assign last_pass = (pass_cnt == PCNT_W'(PASSES - 1));

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state == ACC);
    accept    = in_valid && in_ready;
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC;
      ACC:     if (last_pass) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? ACC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pass_cnt  <= '0;
      out_y     <= 1'b0;
      out_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pass_cnt <= '0;
      end else if (state == ACC) begin
        pass_cnt <= pass_cnt + PCNT_W'(1);
      end
      if ((state == ACC) && last_pass) begin
        out_count <= acc_nxt;
        out_y     <= (acc_nxt >= thr);
      end
    end
  end

  // Request datapath: padding bits above N are zero and contribute nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= PW'(in_x);
      acc   <= '0;
      thr   <= in_thr_en ? in_thr : CW'(MAJ_THR);
    end else if (state == ACC) begin
      shreg <= shreg >> CHUNK;
      acc   <= acc_nxt;
    end
  end

endmodule
